// File: rtl/cdb_host_if.sv
// cdb_host_if
//   CD-block host register interface seen by the SCU on A-bus chip-select 2.
//   It decodes the CD-block window (AA[25:16] == 10'h189) and holds HIRQ,
//   HIRQMASK, the CR1-CR4 response registers and a separate CMD1-CMD4
//   command latch. A small engine answers a command a fixed CMD_LAT CE_R
//   cycles after the CR4 write. Once the first command has completed, a
//   timer posts a periodic status report every PERIOD CE_R cycles.
//
// Ports
//   CLK     in   system clock
//   RST_N   in   asynchronous active-low reset
//   CE_R    in   clock enable; state advances only when high
//   AA      in   [25:0] A-bus address
//   ADO     in   [15:0] A-bus write data
//   ACS2_N  in   A-bus chip-select 2 (active-low)
//   ARD_N   in   read strobe (active-low); reads are combinational and
//                do not depend on it
//   AWRU_N  in   upper-byte write strobe (active-low)
//   AWRL_N  in   lower-byte write strobe (active-low)
//   DO      out  [15:0] read data to SCU ADI
//   IRQ_N   out  registered interrupt request: low while HIRQ & HIRQMASK != 0
//
// Write handshake: a write event happens once per access. It is the first
// CE_R cycle in which the window is hit and at least one write strobe is
// low, provided both strobes were high in the previous CE_R cycle. Each
// byte lane is written only if its own strobe is low.
module cdb_host_if #(
  parameter int unsigned CMD_LAT = 16,
  parameter logic [19:0] PERIOD  = 20'd476000,
  parameter logic [7:0]  STAT    = 8'h01
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [25:0] AA,
  input  logic [15:0] ADO,
  input  logic        ACS2_N,
  input  logic        ARD_N,
  input  logic        AWRU_N,
  input  logic        AWRL_N,
  output logic [15:0] DO,
  output logic        IRQ_N
);

  localparam logic [9:0]  BASE     = 10'h189;
  localparam logic [15:0] OFF_HIRQ = 16'h0008;
  localparam logic [15:0] OFF_MASK = 16'h000C;
  localparam logic [15:0] OFF_CR1  = 16'h0018;
  localparam logic [15:0] OFF_CR2  = 16'h001C;
  localparam logic [15:0] OFF_CR3  = 16'h0020;
  localparam logic [15:0] OFF_CR4  = 16'h0024;
  localparam int          CW       = $clog2(CMD_LAT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [19:0] timer;
  logic        first_done;
  logic        wr_idle_q;   // both write strobes were high last CE_R cycle
  logic        irq_n_q;
  logic [15:0] hirq, hirq_mask;
  logic [15:0] cr1, cr2, cr3, cr4;
  logic [15:0] cmd1, cmd2, cmd3, cmd4;

  logic        hit, wr_active, wr_ev, done;
  logic [15:0] off, lane, hirq_wr;

  assign hit       = !ACS2_N && (AA[25:16] == BASE);
  assign off       = {AA[15:1], 1'b0};
  assign wr_active = !(AWRU_N && AWRL_N);
  assign wr_ev     = hit && wr_active && wr_idle_q;
  assign lane      = {{8{!AWRU_N}}, {8{!AWRL_N}}};
  assign done      = (state == BUSY) && (cnt == CW'(1));

  // Write-0-to-clear; bytes whose strobe is inactive are left unchanged.
  // A CMOK set in the same cycle takes precedence over the host clear.
  always_comb begin
    hirq_wr = hirq;
    if (wr_ev && off == OFF_HIRQ) hirq_wr = hirq & (ADO | ~lane);
    if (done) hirq_wr[0] = 1'b1;
  end

  always_comb begin
    DO = 16'h0000;
    if (hit) begin
      case (off)
        OFF_HIRQ: DO = hirq;
        OFF_MASK: DO = hirq_mask;
        OFF_CR1:  DO = cr1;
        OFF_CR2:  DO = cr2;
        OFF_CR3:  DO = cr3;
        OFF_CR4:  DO = cr4;
        default:  DO = 16'h0000;
      endcase
    end
  end

  assign IRQ_N = irq_n_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      timer      <= PERIOD;
      first_done <= 1'b0;
      wr_idle_q  <= 1'b1;
      irq_n_q    <= 1'b0;
      hirq       <= 16'hFFFF;
      hirq_mask  <= 16'hFFFF;
      cr1        <= 16'h0043;
      cr2        <= 16'h4442;
      cr3        <= 16'h4C4F;
      cr4        <= 16'h434B;
      cmd1       <= '0;
      cmd2       <= '0;
      cmd3       <= '0;
      cmd4       <= '0;
    end else if (CE_R) begin
      wr_idle_q <= !wr_active;
      irq_n_q   <= ~|(hirq & hirq_mask);
      hirq      <= hirq_wr;

      if (wr_ev) begin
        case (off)
          OFF_MASK: hirq_mask <= (ADO & lane) | (hirq_mask & ~lane);
          OFF_CR1:  cmd1 <= (ADO & lane) | (cmd1 & ~lane);
          OFF_CR2:  cmd2 <= (ADO & lane) | (cmd2 & ~lane);
          OFF_CR3:  cmd3 <= (ADO & lane) | (cmd3 & ~lane);
          OFF_CR4:  cmd4 <= (ADO & lane) | (cmd4 & ~lane);
          default:  ;
        endcase
      end

      case (state)
        IDLE: begin
          if (wr_ev && off == OFF_CR4) begin
            state <= BUSY;
            cnt   <= CW'(CMD_LAT);
          end
        end
        BUSY: begin
          // CR4 writes here only update CMD4; the running command is not
          // restarted.
          if (done) begin
            state      <= IDLE;
            first_done <= 1'b1;
            case (cmd1[15:8])
              8'h00: begin
                cr1 <= {STAT, 8'h00}; cr2 <= 16'h0000;
                cr3 <= 16'h0000;      cr4 <= 16'h0000;
              end
              8'h01: begin
                cr1 <= {STAT, 8'h00}; cr2 <= 16'h0201;
                cr3 <= 16'h0000;      cr4 <= 16'h0400;
              end
              default: begin
                cr1 <= 16'hFF00;      cr2 <= 16'h0000;
                cr3 <= 16'h0000;      cr4 <= 16'h0000;
              end
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // The timer is held at PERIOD until the first command completes and
      // while BUSY, so a report can never land on a completion cycle.
      if (state == BUSY || !first_done) begin
        timer <= PERIOD;
      end else if (timer == 20'd1) begin
        timer <= PERIOD;
        cr1   <= {STAT | 8'h20, 8'h00};
        cr2   <= 16'h0000;
        cr3   <= 16'h0000;
        cr4   <= 16'h0000;
      end else begin
        timer <= timer - 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_host_if.sv
module tb_cdb_host_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_r;
  logic [25:0] aa;
  logic [15:0] ado;
  logic        acs2_n, ard_n, awru_n, awrl_n;
  logic [15:0] do_w;
  logic        irq_n;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cdb_host_if #(.CMD_LAT(16), .PERIOD(20'd64), .STAT(8'h01)) dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .AA(aa), .ADO(ado),
    .ACS2_N(acs2_n), .ARD_N(ard_n), .AWRU_N(awru_n), .AWRL_N(awrl_n),
    .DO(do_w), .IRQ_N(irq_n)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // drivers
  task automatic bus_read(input logic [9:0] base, input logic cs_n, input logic [15:0] off,
                          output logic [15:0] d);
    aa = {base, off};
    acs2_n = cs_n;
    ard_n = 1'b0;
    #1;
    d = do_w;
    acs2_n = 1'b1;
    ard_n = 1'b1;
  endtask

  task automatic rd(input logic [15:0] off, output logic [15:0] d);
    bus_read(10'h189, 1'b0, off, d);
  endtask

  // Strobes are low for exactly one rising edge (the write-event edge); the
  // task returns at the falling edge right after it.
  task automatic bus_write_b(input logic [15:0] off, input logic [15:0] d,
                             input logic up, input logic lo);
    @(negedge clk);
    aa = {10'h189, off};
    ado = d;
    acs2_n = 1'b0;
    awru_n = !up;
    awrl_n = !lo;
    @(negedge clk);
    acs2_n = 1'b1;
    awru_n = 1'b1;
    awrl_n = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] off, input logic [15:0] d);
    bus_write_b(off, d, 1'b1, 1'b1);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  typedef struct {
    logic [9:0]  base;
    logic        cs_n;
    logic [15:0] off;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t rv[10];

  initial begin
    logic [15:0] d;
    int t0, t1;

    rv[0] = '{10'h189, 1'b0, 16'h0008, 16'hFFFF};
    rv[1] = '{10'h189, 1'b0, 16'h000C, 16'hFFFF};
    rv[2] = '{10'h189, 1'b0, 16'h0018, 16'h0043};
    rv[3] = '{10'h189, 1'b0, 16'h001C, 16'h4442};
    rv[4] = '{10'h189, 1'b0, 16'h0020, 16'h4C4F};
    rv[5] = '{10'h189, 1'b0, 16'h0024, 16'h434B};
    rv[6] = '{10'h189, 1'b0, 16'h0004, 16'h0000};
    rv[7] = '{10'h189, 1'b0, 16'h0019, 16'h0043};
    rv[8] = '{10'h188, 1'b0, 16'h0018, 16'h0000};
    rv[9] = '{10'h189, 1'b1, 16'h0018, 16'h0000};

    rst_n = 1'b0; ce_r = 1'b1; aa = '0; ado = '0;
    acs2_n = 1'b1; ard_n = 1'b1; awru_n = 1'b1; awrl_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset values through the read path
    for (int i = 0; i < 10; i++) begin
      bus_read(rv[i].base, rv[i].cs_n, rv[i].off, d);
      check($sformatf("rd_%0d_off_%h", i, rv[i].off), d, rv[i].exp);
    end
    check("irq_n_reset", {15'b0, irq_n}, 16'h0000);

    // no periodic report before the first command
    repeat (70) @(negedge clk);
    rd(16'h0018, d); check("no_report_before_cmd", d, 16'h0043);

    // byte lanes
    bus_write_b(16'h0008, 16'h00F0, 1'b0, 1'b1);
    rd(16'h0008, d); check("hirq_lower_lane", d, 16'hFFF0);
    bus_write_b(16'h0008, 16'h0F00, 1'b1, 1'b0);
    rd(16'h0008, d); check("hirq_upper_lane", d, 16'h0FF0);
    bus_write_b(16'h000C, 16'hAB34, 1'b1, 1'b0);
    rd(16'h000C, d); check("mask_upper_lane", d, 16'hABFF);

    // HIRQ clear, mask store
    bus_write(16'h0008, 16'h0000);
    bus_write(16'h000C, 16'h0001);
    rd(16'h0008, d); check("hirq_cleared", d, 16'h0000);
    rd(16'h000C, d); check("mask_stored", d, 16'h0001);
    @(negedge clk);
    check("irq_n_masked", {15'b0, irq_n}, 16'h0001);

    // writes with CE_R low are ignored
    ce_r = 1'b0;
    bus_write(16'h000C, 16'hFFFF);
    ce_r = 1'b1;
    rd(16'h000C, d); check("ce_low_no_write", d, 16'h0001);

    // GetHwInfo command
    bus_write(16'h0018, 16'h0100);
    rd(16'h0018, d); check("cr1_write_not_resp", d, 16'h0043);
    bus_write(16'h001C, 16'h0000);
    bus_write(16'h0020, 16'h0000);
    bus_write(16'h0024, 16'h0000);
    t0 = cyc;
    wait_to(t0 + 15);
    rd(16'h0008, d); check("hwinfo_hirq_t15", d, 16'h0000);
    rd(16'h0018, d); check("hwinfo_cr1_t15", d, 16'h0043);
    wait_to(t0 + 16);
    rd(16'h0008, d); check("hwinfo_hirq_t16", d, 16'h0001);
    rd(16'h0018, d); check("hwinfo_cr1", d, 16'h0100);
    rd(16'h001C, d); check("hwinfo_cr2", d, 16'h0201);
    rd(16'h0020, d); check("hwinfo_cr3", d, 16'h0000);
    rd(16'h0024, d); check("hwinfo_cr4", d, 16'h0400);
    check("irq_n_lag_t16", {15'b0, irq_n}, 16'h0001);
    wait_to(t0 + 17);
    check("irq_n_t17", {15'b0, irq_n}, 16'h0000);

    // reject opcode, second CR4 write during BUSY is dropped
    bus_write(16'h0008, 16'h0000);
    bus_write(16'h0018, 16'h5500);
    bus_write(16'h0024, 16'h0000);
    t0 = cyc;
    wait_to(t0 + 4);
    bus_write(16'h0024, 16'h1234);
    wait_to(t0 + 15);
    rd(16'h0008, d); check("reject_hirq_t15", d, 16'h0000);
    wait_to(t0 + 16);
    t1 = cyc;
    rd(16'h0008, d); check("reject_hirq_t16", d, 16'h0001);
    rd(16'h0018, d); check("reject_cr1", d, 16'hFF00);
    rd(16'h001C, d); check("reject_cr2", d, 16'h0000);
    bus_write(16'h0008, 16'h0000);
    wait_to(t1 + 30);
    rd(16'h0008, d); check("single_cmok", d, 16'h0000);

    // periodic report, PERIOD=64 after completion
    wait_to(t1 + 63);
    rd(16'h0018, d); check("period_cr1_t63", d, 16'hFF00);
    wait_to(t1 + 64);
    rd(16'h0018, d); check("period_cr1_t64", d, 16'h2100);
    rd(16'h0024, d); check("period_cr4", d, 16'h0000);
    rd(16'h0008, d); check("period_hirq", d, 16'h0000);

    // HIRQ clear on the completion cycle: set wins
    bus_write(16'h0018, 16'h0000);
    bus_write(16'h0024, 16'h0000);
    t0 = cyc;
    wait_to(t0 + 14);
    bus_write(16'h0008, 16'h0000);
    rd(16'h0008, d); check("set_wins_hirq", d, 16'h0001);
    rd(16'h0018, d); check("getstatus_cr1", d, 16'h0100);
    rd(16'h001C, d); check("getstatus_cr2", d, 16'h0000);

    // reset mid-BUSY
    bus_write(16'h0018, 16'h0100);
    bus_write(16'h0024, 16'h0000);
    t0 = cyc;
    wait_to(t0 + 5);
    rst_n = 1'b0;
    #1;
    rd(16'h0018, d); check("rst_cr1", d, 16'h0043);
    rd(16'h0008, d); check("rst_hirq", d, 16'hFFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_write(16'h0008, 16'h0000);
    t1 = cyc;
    wait_to(t1 + 30);
    rd(16'h0008, d); check("rst_no_cmok", d, 16'h0000);
    rd(16'h0018, d); check("rst_cr1_after", d, 16'h0043);
    rd(16'h0024, d); check("rst_cr4_after", d, 16'h434B);
    rd(16'h000C, d); check("rst_mask", d, 16'hFFFF);
    check("rst_irq_n", {15'b0, irq_n}, 16'h0001);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_host_if.md
# cdb_host_if

CD-block host register interface: the A-bus slave behind the SCU's A-bus chip-select 2, decoding the CD-block window at AA[25:16]=10'h189. It holds HIRQ, HIRQMASK and the CR1–CR4 command/response registers. It runs a small command engine that answers host commands after a fixed latency and posts periodic status reports. It drives the SCU's A-bus read data (ADI) and interrupt request (AIRQ_N).

## Interface
- CMD_LAT, 16: CE_R cycles from a command trigger to response/CMOK.
- PERIOD, 20'd476000: CE_R cycles between periodic status reports.
- STAT, 8'h01: drive status byte (PAUSE) placed in CR1[15:8].

Ports:
- CLK  in  1  system clock; single clock domain.
- RST_N  in  1  reset, asynchronous, active-low.
- CE_R  in  1  clock enable; all state advances only when high.
- AA  in  26  A-bus address from SCU.
- ADO  in  16  A-bus write data from SCU.
- ACS2_N  in  1  A-bus CS2, active-low.
- ARD_N  in  1  read strobe, active-low.
- AWRU_N  in  1  upper-byte write strobe, active-low.
- AWRL_N  in  1  lower-byte write strobe, active-low.
- DO  out  16  read data to SCU ADI.
- IRQ_N  out  1  to SCU AIRQ_N; low while (HIRQ & HIRQMASK) != 0.

## Operation
- Hit = !ACS2_N && AA[25:16]==10'h189. Offsets use {AA[15:1],1'b0}: 08 HIRQ, 0C HIRQMASK, 18 CR1, 1C CR2, 20 CR3, 24 CR4.
- Read path is combinational. On a hit with a decoded offset, DO = register; otherwise DO=16'h0000. CR reads return the response registers.
- Write event: first CE_R cycle of a hit with (AWRU_N & AWRL_N) low after both were high in the previous CE_R cycle. Exactly one event per access. Byte lanes apply per strobe.
- HIRQ write: HIRQ <= HIRQ & wdata (write-0-to-clear; writing 1 leaves a bit unchanged). HIRQMASK write: plain store.
- CR1–CR4 writes go to a separate command latch CMD1–CMD4. They never alter the response registers.
- CR4 write event while IDLE arms the engine: IDLE→BUSY, counter loaded with CMD_LAT. A CR4 write while BUSY updates CMD4 but is not retriggered (dropped).
- BUSY decrements each CE_R. When it reaches 0, the engine loads the response, sets HIRQ[0] (CMOK), sets the first-command-done flag, and returns to IDLE.
- Response by opcode CMD1[15:8]:
  - 8'h00 GetStatus → CR1={STAT,8'h00}, CR2..CR4=0.
  - 8'h01 GetHwInfo → CR1={STAT,8'h00}, CR2=16'h0201, CR3=16'h0000, CR4=16'h0400.
  - Other → CR1=16'hFF00 (REJECT), CR2..CR4=0.
- Periodic timer: runs only in IDLE after the first command has completed. It is held at PERIOD while BUSY. On expiry it writes CR1={STAT|8'h20,8'h00}, CR2..CR4=0, leaves HIRQ unchanged, and reloads.
- Simultaneous HIRQ host write and CMOK set in the same CE_R: the set wins (HIRQ <= (HIRQ & wdata) | 16'h0001).
- Periodic expiry and command completion cannot coincide, because the timer is held while BUSY.

## Timing
- Reset values:
  - HIRQ=16'hFFFF, HIRQMASK=16'hFFFF.
  - CR1..CR4=16'h0043, 16'h4442, 16'h4C4F, 16'h434B ("CDBLOCK" signature).
  - CMD1..4=0, state IDLE, first-command-done=0, timer=PERIOD.
  - IRQ_N=0 (HIRQ&mask nonzero). DO=0 when not selected.
- IRQ_N is registered: it reflects HIRQ/HIRQMASK one CE_R after they change.
- CMOK rises exactly CMD_LAT CE_R cycles after the CE_R cycle that registers the CR4 write event.
- Periodic report lands PERIOD CE_R cycles after the timer is released or reloaded.
- RST_N assertion mid-BUSY or mid-access aborts immediately to reset values. No response is posted.

## Test plan
- Reset → read 08/0C/18/1C/20/24 = FFFF/FFFF/0043/4442/4C4F/434B; IRQ_N=0; read offset 04 = 0000.
- Write HIRQ=0000, HIRQMASK=0001 → HIRQ reads 0000; IRQ_N=1 one CE_R later.
- Write CR1=0100, CR2..3=0, CR4=0 → after 16 CE_R: CR1..4=0100/0201/0000/0400, HIRQ[0]=1, IRQ_N=0. CR reads before completion still show signature.
- Command 8'h55 → CR1=FF00; a second CR4 write during BUSY → exactly one CMOK set, completion still 16 CE_R after the first trigger.
- After a completed command, PERIOD=64 (override): clear HIRQ → 64 CE_R later CR1=2100, HIRQ stays 0000; no report before the first command.
- HIRQ write 0000 on the exact CE_R completion occurs → HIRQ=0001; assert RST_N low mid-BUSY → signature restored, CMOK never set.
